// File: rtl/clk_ratio_monitor.sv
`timescale 1ns/100ps
// clk_ratio_monitor
//   Receive-side monitor for slow square waves (divided clocks, reference
//   ticks). sig_in is synchronised into the clk domain. Its rise-to-rise
//   period and rise-to-fall high time are measured in clk cycles. Lock is
//   declared once LOCK_CNT consecutive measurements report the same period.
//   If the input stops toggling, a timeout is flagged and the monitor
//   re-arms.
//
// Ports
//   clk        fast sampling clock
//   rst_n      asynchronous active-low reset
//   sig_in     monitored signal, asynchronous to clk
//   period     last measured rise-to-rise distance (clk cycles)
//   high_time  last measured rise-to-fall distance (clk cycles)
//   meas_valid one-cycle pulse when period/high_time update
//   locked     LOCK_CNT consecutive equal periods observed
//   timeout    one-cycle pulse: no rising edge for TIMEOUT cycles
module clk_ratio_monitor #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [CNT_W-1:0] period_nxt, high_nxt;
    logic             mv_nxt, locked_nxt, to_nxt;

    // Counters stick at all-ones rather than wrapping, so a very slow
    // input can never alias to a short period.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [MW-1:0] match_inc(input logic [MW-1:0] v);
        return (v == LOCK_VAL) ? v : v + MW'(1);
    endfunction

    // Synchroniser: s1/s2 resolve metastability, s3 provides edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Both counters restart at 1 on a rise so that, at the following rise,
    // they hold exactly the rise-to-rise and rise-to-fall distances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else begin
            per_cnt <= sat_inc(per_cnt);
            if (s2) begin
                hi_cnt <= sat_inc(hi_cnt);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        period_nxt = period;
        high_nxt   = high_time;
        match_nxt  = match_cnt;
        locked_nxt = locked;
        mv_nxt     = 1'b0;
        to_nxt     = 1'b0;
        case (state)
            IDLE: begin
                // The first rise only establishes a reference point.
                if (rise) begin
                    state_nxt = ARMED;
                end
            end
            ARMED, TRACK: begin
                if (rise) begin
                    period_nxt = per_cnt;
                    high_nxt   = hi_cnt;
                    mv_nxt     = 1'b1;
                    state_nxt  = TRACK;
                    // A stale period left over from before a timeout must
                    // not count toward lock, hence the ARMED restart.
                    if (state == TRACK && per_cnt == period) begin
                        match_nxt = match_inc(match_cnt);
                    end else begin
                        match_nxt = MW'(1);
                    end
                    locked_nxt = (match_nxt == LOCK_VAL);
                end else if (per_cnt == TO_VAL) begin
                    to_nxt     = 1'b1;
                    locked_nxt = 1'b0;
                    match_nxt  = '0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period     <= '0;
            high_time  <= '0;
            match_cnt  <= '0;
            locked     <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            period     <= period_nxt;
            high_time  <= high_nxt;
            match_cnt  <= match_nxt;
            locked     <= locked_nxt;
            meas_valid <= mv_nxt;
            timeout    <= to_nxt;
        end
    end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
`timescale 1ns/100ps
// tb_clk_ratio_monitor
//   Directed stimulus for clk_ratio_monitor. A timestamp-based model turns
//   the sampled input edges into expected measurements, lock and timeout,
//   and is compared against the DUT every cycle. Literal checks at phase
//   boundaries pin the model to hand-computed values.
module tb_clk_ratio_monitor;

    localparam int CNT_W    = 16;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 1024;

    logic             clk;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clk_ratio_monitor #(
        .CNT_W   (CNT_W),
        .LOCK_CNT(LOCK_CNT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: edge timestamps in units of active clock edges.
    int  n = 0;
    bit  prev_samp = 1'b0;
    int  ev_t[$];
    bit  ev_v[$];
    bit  have_ref = 1'b0;
    int  last_rise = 0;
    bit  fall_seen = 1'b0;
    int  last_fall = 0;
    int  pers[$];
    int  e_period = 0, e_high = 0;
    bit  e_mv = 1'b0, e_to = 1'b0, e_locked = 1'b0;

    // Observations used by the literal checks.
    int  mv_count = 0, to_seen = 0;
    bit  saw_1024 = 1'b0;
    bit  async_ph = 1'b0;
    int  mv_async = 0, lock_async = 0;
    bit  seen5 = 1'b0, seen6 = 1'b0;

    always @(posedge clk) begin
        bit rise_ev, fall_ev, all_eq;
        if (!rst_n) begin
            ev_t.delete();
            ev_v.delete();
            pers.delete();
            prev_samp = 1'b0;
            have_ref  = 1'b0;
            fall_seen = 1'b0;
            e_period  = 0;
            e_high    = 0;
            e_mv      = 1'b0;
            e_to      = 1'b0;
            e_locked  = 1'b0;
        end else begin
            n++;
            // A change captured at edge k is acted on at edge k+2.
            if (sig_in != prev_samp) begin
                ev_t.push_back(n + 2);
                ev_v.push_back(sig_in);
                prev_samp = sig_in;
            end
            rise_ev = 1'b0;
            fall_ev = 1'b0;
            while (ev_t.size() > 0 && ev_t[0] == n) begin
                if (ev_v[0]) rise_ev = 1'b1;
                else         fall_ev = 1'b1;
                void'(ev_t.pop_front());
                void'(ev_v.pop_front());
            end
            e_mv = 1'b0;
            e_to = 1'b0;
            if (rise_ev) begin
                if (have_ref) begin
                    e_period = n - last_rise;
                    e_high   = fall_seen ? (last_fall - last_rise) : (n - last_rise);
                    e_mv     = 1'b1;
                    pers.push_back(e_period);
                    if (pers.size() > LOCK_CNT) void'(pers.pop_front());
                    all_eq = (pers.size() == LOCK_CNT);
                    foreach (pers[i]) if (pers[i] != e_period) all_eq = 1'b0;
                    e_locked = all_eq;
                end
                have_ref  = 1'b1;
                last_rise = n;
                fall_seen = 1'b0;
            end else if (have_ref && (n - last_rise) == TIMEOUT) begin
                e_to     = 1'b1;
                e_locked = 1'b0;
                have_ref = 1'b0;
                pers.delete();
            end
            if (fall_ev) begin
                fall_seen = 1'b1;
                last_fall = n;
            end
        end
        #1;
        chk("meas_valid", int'(meas_valid), int'(e_mv));
        chk("timeout",    int'(timeout),    int'(e_to));
        chk("locked",     int'(locked),     int'(e_locked));
        chk("period",     int'(period),     e_period);
        chk("high_time",  int'(high_time),  e_high);
        if (meas_valid) begin
            mv_count++;
            if (period == 1024) saw_1024 = 1'b1;
            if (async_ph) begin
                mv_async++;
                if (period == 5) seen5 = 1'b1;
                if (period == 6) seen6 = 1'b1;
            end
        end
        if (timeout) to_seen++;
        if (async_ph && mv_async >= 2 && locked) lock_async++;
    end

    // Synchronous square wave driven on the falling edge, starting high.
    task automatic gen(input int per, input int hi, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            sig_in = ((i % per) < hi);
        end
    endtask

    // 55 ns period against a 10 ns clock: edges land 1/8.5/6/3.5 ns past
    // a falling edge, never on a rising edge.
    task automatic async_run(input int nper);
        @(negedge clk);
        #1;
        for (int i = 0; i < nper; i++) begin
            sig_in = 1'b1;
            #27.5;
            sig_in = 1'b0;
            #27.5;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"},     int'(period),     0);
        chk({tag, "_high_time"},  int'(high_time),  0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0);
        chk({tag, "_locked"},     int'(locked),     0);
        chk({tag, "_timeout"},    int'(timeout),    0);
    endtask

    initial begin
        int t0, m0;
        sig_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Static input after reset: no timeout may fire.
        repeat (1100) @(negedge clk);
        chk("idle_no_timeout", to_seen, 0);

        gen(4, 2, 40);
        chk("div4_period", int'(period), 4);
        chk("div4_high", int'(high_time), 2);
        chk("div4_locked", int'(locked), 1);

        gen(6, 1, 60);
        chk("p6_period", int'(period), 6);
        chk("p6_high", int'(high_time), 1);
        chk("p6_locked", int'(locked), 1);

        gen(4, 2, 40);
        gen(8, 4, 80);
        chk("p8_period", int'(period), 8);
        chk("p8_high", int'(high_time), 4);
        chk("p8_locked", int'(locked), 1);

        gen(4, 2, 40);
        t0 = to_seen;
        sig_in = 1'b0;
        repeat (1100) @(negedge clk);
        chk("timeout_once", to_seen - t0, 1);
        chk("timeout_unlocked", int'(locked), 0);
        chk("timeout_period_hold", int'(period), 4);
        m0 = mv_count;
        gen(4, 2, 12);
        chk("rearm_meas_count", mv_count - m0, 2);

        t0 = to_seen;
        gen(1024, 512, 3072);
        chk("p1024_seen", int'(saw_1024), 1);
        chk("p1024_no_timeout", to_seen - t0, 0);

        gen(2, 1, 20);
        chk("p2_period", int'(period), 2);
        chk("p2_high", int'(high_time), 1);
        chk("p2_locked", int'(locked), 1);

        gen(4, 2, 40);
        chk("pre_rst_locked", int'(locked), 1);
        @(negedge clk);
        sig_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gen(4, 2, 40);
        chk("post_rst_locked", int'(locked), 1);

        async_ph = 1'b1;
        async_run(30);
        repeat (4) @(negedge clk);
        async_ph = 1'b0;
        chk("async_seen5", int'(seen5), 1);
        chk("async_seen6", int'(seen6), 1);
        chk("async_never_locked", lock_async, 0);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
